wb_port_writer: RTL

- Write-side master for the 64-entry integer/float register file; drives its single write port (regwrite, writereg, floatwb, writedata).
- Merges three result producers into one registered write per cycle:
  - ALU pipe: no backpressure, highest priority.
  - Load unit (LSU): valid/ready.
  - Multi-cycle FPU: valid/ready.
- Per-source FIFOs absorb contention; the block honours the pipeline stall, during which the register file ignores writes.

---
 rtl/wb_port_writer_if.sv | 37 +++
 rtl/wb_port_writer.sv | 99 +++++++++
 2 files changed

// File: rtl/wb_port_writer_if.sv
// wb_port_writer_if: result channels from ALU/LSU/FPU plus the register-file write port
interface wb_port_writer_if #(
  parameter int DW = 32
);
  logic          stall;
  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic          alu_float;
  logic [DW-1:0] alu_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [4:0]    lsu_rd;
  logic          lsu_float;
  logic [DW-1:0] lsu_data;
  logic          fpu_valid;
  logic          fpu_ready;
  logic [4:0]    fpu_rd;
  logic          fpu_float;
  logic [DW-1:0] fpu_data;
  logic          regwrite;
  logic [4:0]    writereg;
  logic          floatwb;
  logic [DW-1:0] writedata;
  logic          busy;
  modport slave (
    input  stall, alu_valid, alu_rd, alu_float, alu_data,
    input  lsu_valid, lsu_rd, lsu_float, lsu_data,
    input  fpu_valid, fpu_rd, fpu_float, fpu_data,
    output lsu_ready, fpu_ready, regwrite, writereg, floatwb, writedata, busy
  );
  modport master (
    output stall, alu_valid, alu_rd, alu_float, alu_data,
    output lsu_valid, lsu_rd, lsu_float, lsu_data,
    output fpu_valid, fpu_rd, fpu_float, fpu_data,
    input  lsu_ready, fpu_ready, regwrite, writereg, floatwb, writedata, busy
  );
endinterface

// File: rtl/wb_port_writer.sv
// wb_port_writer: merges ALU, LSU and FPU results into one registered register-file write per cycle
module wb_port_writer #(
  parameter int DEPTH = 2,
  parameter int DW    = 32
) (
  input logic            clk,
  input logic            rst_n,
  wb_port_writer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DW + 6;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [EW-1:0] mem_q [2][DEPTH];
  logic [EW-1:0] in_ent [2];
  logic [EW-1:0] cand [2];
  logic [AW:0]   cnt_q [2];
  logic [AW:0]   cnt_d [2];
  logic [AW-1:0] rp_q [2];
  logic [AW-1:0] rp_d [2];
  logic [AW-1:0] wp_q [2];
  logic [AW-1:0] wp_d [2];
  logic [1:0]    in_valid, in_ready, in_live, cand_v, grant, push, pop;
  logic          alu_go, rr_q, rr_d;
  logic          regwrite_q, regwrite_d, floatwb_q, floatwb_d;
  logic [4:0]    writereg_q, writereg_d;
  logic [DW-1:0] writedata_q, writedata_d;
  logic [EW-1:0] alu_ent, hold_ent, out_ent;
  // index 0 = LSU, 1 = FPU; entries pack {float, rd, data}
  assign in_valid  = {bus.fpu_valid, bus.lsu_valid};
  assign in_ent[0] = {bus.lsu_float, bus.lsu_rd, bus.lsu_data};
  assign in_ent[1] = {bus.fpu_float, bus.fpu_rd, bus.fpu_data};
  assign alu_ent   = {bus.alu_float, bus.alu_rd, bus.alu_data};
  assign hold_ent  = {floatwb_q, writereg_q, writedata_q};
  always_comb begin
    alu_go   = !bus.stall && bus.alu_valid && (bus.alu_rd != 5'd0 || bus.alu_float);
    in_ready = '0;
    in_live  = '0;
    cand_v   = '0;
    grant    = '0;
    push     = '0;
    pop      = '0;
    for (int s = 0; s < 2; s++) begin
      in_ready[s] = cnt_q[s] < FULL;
      in_live[s]  = in_valid[s] && in_ready[s] && (in_ent[s][DW+4:DW] != 5'd0 || in_ent[s][EW-1]);
      cand[s]     = (cnt_q[s] != '0) ? mem_q[s][rp_q[s]] : in_ent[s];
      cand_v[s]   = (cnt_q[s] != '0) || in_live[s];
    end
    if (!bus.stall && !alu_go) begin
      grant[0] = cand_v[0] && (!cand_v[1] || !rr_q);
      grant[1] = cand_v[1] && !grant[0];
    end
    rr_d = grant[0] ? 1'b1 : grant[1] ? 1'b0 : rr_q;
    // a granted bypass candidate is consumed without ever touching the FIFO
    for (int s = 0; s < 2; s++) begin
      pop[s]   = grant[s] && cnt_q[s] != '0;
      push[s]  = in_live[s] && !(grant[s] && cnt_q[s] == '0);
      cnt_d[s] = cnt_q[s] + (AW+1)'(push[s]) - (AW+1)'(pop[s]);
      wp_d[s]  = wp_q[s] + AW'(push[s]);
      rp_d[s]  = rp_q[s] + AW'(pop[s]);
    end
    out_ent    = bus.stall ? hold_ent : alu_go ? alu_ent : grant[0] ? cand[0] : grant[1] ? cand[1] : hold_ent;
    regwrite_d = bus.stall ? regwrite_q : (alu_go || (|grant));
    {floatwb_d, writereg_d, writedata_d} = out_ent;
  end
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++)
      if (push[s]) mem_q[s][wp_q[s]] <= in_ent[s];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        cnt_q[s] <= '0;
        rp_q[s]  <= '0;
        wp_q[s]  <= '0;
      end
      rr_q        <= 1'b0;
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      floatwb_q   <= 1'b0;
      writedata_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      rp_q        <= rp_d;
      wp_q        <= wp_d;
      rr_q        <= rr_d;
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      floatwb_q   <= floatwb_d;
      writedata_q <= writedata_d;
    end
  end
  assign bus.lsu_ready = in_ready[0];
  assign bus.fpu_ready = in_ready[1];
  assign bus.regwrite  = regwrite_q;
  assign bus.writereg  = writereg_q;
  assign bus.floatwb   = floatwb_q;
  assign bus.writedata = writedata_q;
  assign bus.busy      = (cnt_q[0] != '0) || (cnt_q[1] != '0) || regwrite_q;
endmodule
